// File: rtl/uart_fifo.sv
// Byte FIFO between the UART datapath and host logic: first-word-fall-through
// read port, occupancy-based flags and sticky overflow/underflow error bits.
module uart_fifo #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,
   parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 1,
   parameter int AE_THRESH  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AF_C    = AF_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AE_C    = AE_THRESH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_r;
   logic [ADDR_WIDTH-1:0] rd_ptr_r;
   logic [ADDR_WIDTH:0]   count_r;
   logic                  overflow_r;
   logic                  underflow_r;

   logic                  push_s;
   logic                  pop_s;
   logic                  ovf_evt_s;
   logic                  unf_evt_s;
   logic                  full_s;
   logic                  empty_s;
   logic [ADDR_WIDTH:0]   count_nxt_s;

   // Flags decode only the registered count, so they never follow wr/rd directly.
   assign full_s  = (count_r == DEPTH_C);
   assign empty_s = (count_r == {(ADDR_WIDTH+1){1'b0}});

   // Handshake decode: a pop on a full FIFO frees the slot for the same-edge push.
   always_comb begin
      push_s    = wr && (!full_s || rd);
      pop_s     = rd && !empty_s;
      ovf_evt_s = wr && full_s && !rd;
      unf_evt_s = rd && empty_s;
   end

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + (ADDR_WIDTH+1)'(1);
         2'b01:   count_nxt_s = count_r - (ADDR_WIDTH+1)'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Storage array; contents are deliberately left unreset, the empty mask hides stale data.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= w_data;
      end
   end

   // Pointers, occupancy and sticky error bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
         count_r     <= {(ADDR_WIDTH+1){1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
         end
         count_r <= count_nxt_s;
         // A fresh error event outranks a clear requested in the same cycle.
         if (ovf_evt_s) begin
            overflow_r <= 1'b1;
         end else if (clr_err) begin
            overflow_r <= 1'b0;
         end
         if (unf_evt_s) begin
            underflow_r <= 1'b1;
         end else if (clr_err) begin
            underflow_r <= 1'b0;
         end
      end
   end

   // Fall-through head entry, forced to zero while empty.
   always_comb begin
      if (empty_s) begin
         r_data = {DATA_WIDTH{1'b0}};
      end else begin
         r_data = mem_r[rd_ptr_r];
      end
   end

   assign count        = count_r;
   assign full         = full_s;
   assign empty        = empty_s;
   assign almost_full  = (count_r >= AF_C);
   assign almost_empty = (count_r <= AE_C);
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo: default 8-deep instance plus two
// corner-parameter instances for threshold and width boundaries.
module tb_uart_fifo;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   // default instance: DEPTH=8, AF=7, AE=1
   logic       wr_a = 1'b0, rd_a = 1'b0, clr_a = 1'b0;
   logic [7:0] wd_a = 8'h00, rdat_a;
   logic [3:0] cnt_a;
   logic       full_a, empty_a, af_a, ae_a, ovf_a, unf_a;

   uart_fifo u_a (
      .clk(clk), .reset(reset), .wr(wr_a), .w_data(wd_a), .rd(rd_a),
      .r_data(rdat_a), .count(cnt_a), .full(full_a), .empty(empty_a),
      .almost_full(af_a), .almost_empty(ae_a), .overflow(ovf_a),
      .underflow(unf_a), .clr_err(clr_a)
   );

   // DEPTH=2, 1-bit data, AF=DEPTH, AE=0
   logic       wr_b = 1'b0, rd_b = 1'b0;
   logic [0:0] wd_b = 1'b0, rdat_b;
   logic [1:0] cnt_b;
   logic       full_b, empty_b, af_b, ae_b, ovf_b, unf_b;

   uart_fifo #(.ADDR_WIDTH(1), .DATA_WIDTH(1), .AF_THRESH(2), .AE_THRESH(0)) u_b (
      .clk(clk), .reset(reset), .wr(wr_b), .w_data(wd_b), .rd(rd_b),
      .r_data(rdat_b), .count(cnt_b), .full(full_b), .empty(empty_b),
      .almost_full(af_b), .almost_empty(ae_b), .overflow(ovf_b),
      .underflow(unf_b), .clr_err(1'b0)
   );

   // DEPTH=16, 16-bit data, AF=DEPTH, AE=0
   logic        wr_c = 1'b0, rd_c = 1'b0;
   logic [15:0] wd_c = 16'h0000, rdat_c;
   logic [4:0]  cnt_c;
   logic        full_c, empty_c, af_c, ae_c, ovf_c, unf_c;

   uart_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .AF_THRESH(16), .AE_THRESH(0)) u_c (
      .clk(clk), .reset(reset), .wr(wr_c), .w_data(wd_c), .rd(rd_c),
      .r_data(rdat_c), .count(cnt_c), .full(full_c), .empty(empty_c),
      .almost_full(af_c), .almost_empty(ae_c), .overflow(ovf_c),
      .underflow(unf_c), .clr_err(1'b0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [7:0] d);
      wr_a = 1'b1; wd_a = d;
      tick();
      wr_a = 1'b0;
   endtask

   task automatic pop_a();
      rd_a = 1'b1;
      tick();
      rd_a = 1'b0;
   endtask

   initial begin
      // reset state
      tick();
      chk("rst_count", cnt_a, 0);
      chk("rst_empty", empty_a, 1);
      chk("rst_full", full_a, 0);
      chk("rst_ae", ae_a, 1);
      chk("rst_af", af_a, 0);
      chk("rst_ovf", ovf_a, 0);
      chk("rst_unf", unf_a, 0);
      chk("rst_rdata", rdat_a, 0);
      reset = 1'b0;

      // mid-stream reset is immediate, first push after release is the head
      for (int i = 0; i < 5; i++) push_a(8'h10 + 8'(i));
      chk("pre_rst_count", cnt_a, 5);
      chk("pre_rst_head", rdat_a, 8'h10);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_count", cnt_a, 0);
      chk("async_rst_empty", empty_a, 1);
      chk("async_rst_rdata", rdat_a, 0);
      tick();
      reset = 1'b0;
      push_a(8'hA5);
      chk("post_rst_rdata", rdat_a, 8'hA5);
      chk("post_rst_count", cnt_a, 1);
      pop_a();
      chk("post_rst_empty", empty_a, 1);

      // fill and drain
      for (int i = 1; i <= 8; i++) begin
         push_a(8'(i));
         chk("fill_count", cnt_a, i);
         chk("fill_af", af_a, (i >= 7));
         chk("fill_full", full_a, (i == 8));
         chk("fill_ae", ae_a, (i <= 1));
      end
      chk("fill_head", rdat_a, 8'h01);
      for (int i = 1; i <= 8; i++) begin
         chk("drain_data", rdat_a, i);
         pop_a();
         chk("drain_count", cnt_a, 8 - i);
         chk("drain_ae", ae_a, ((8 - i) <= 1));
         chk("drain_empty", empty_a, (i == 8));
      end

      // wrap-around with occupancy held at 3
      for (int i = 0; i < 3; i++) push_a(8'h20 + 8'(i));
      for (int k = 0; k < 20; k++) begin
         chk("wrap_head", rdat_a, 8'h20 + 8'(k));
         wr_a = 1'b1; rd_a = 1'b1; wd_a = 8'h23 + 8'(k);
         tick();
         wr_a = 1'b0; rd_a = 1'b0;
         chk("wrap_count", cnt_a, 3);
      end
      for (int i = 0; i < 3; i++) begin
         chk("wrap_tail", rdat_a, 8'h34 + 8'(i));
         pop_a();
      end
      chk("wrap_ovf", ovf_a, 0);
      chk("wrap_unf", unf_a, 0);

      // overflow, then simultaneous push/pop on full
      for (int i = 0; i < 8; i++) push_a(8'h40 + 8'(i));
      chk("ovf_pre", ovf_a, 0);
      push_a(8'hFF);
      chk("ovf_count", cnt_a, 8);
      chk("ovf_flag", ovf_a, 1);
      chk("ovf_head", rdat_a, 8'h40);
      wr_a = 1'b1; rd_a = 1'b1; wd_a = 8'hFF;
      tick();
      wr_a = 1'b0; rd_a = 1'b0;
      chk("full_rw_count", cnt_a, 8);
      chk("full_rw_ovf", ovf_a, 1);
      chk("full_rw_head", rdat_a, 8'h41);
      for (int i = 1; i < 8; i++) begin
         chk("ovf_drain", rdat_a, 8'h40 + 8'(i));
         pop_a();
      end
      chk("ovf_tail", rdat_a, 8'hFF);
      pop_a();
      chk("ovf_drained", empty_a, 1);

      // clear, underflow, empty push+pop, clear-vs-event priority
      clr_a = 1'b1; tick(); clr_a = 1'b0;
      chk("clr_ovf", ovf_a, 0);
      chk("clr_unf", unf_a, 0);
      pop_a();
      chk("unf_flag", unf_a, 1);
      chk("unf_count", cnt_a, 0);
      chk("unf_rdata", rdat_a, 0);
      wr_a = 1'b1; rd_a = 1'b1; wd_a = 8'h3C;
      tick();
      wr_a = 1'b0; rd_a = 1'b0;
      chk("empty_rw_count", cnt_a, 1);
      chk("empty_rw_rdata", rdat_a, 8'h3C);
      chk("empty_rw_unf", unf_a, 1);
      pop_a();
      chk("empty_rw_drain", cnt_a, 0);
      clr_a = 1'b1; rd_a = 1'b1;
      tick();
      clr_a = 1'b0; rd_a = 1'b0;
      chk("clr_vs_unf", unf_a, 1);
      chk("clr_vs_unf_ovf", ovf_a, 0);
      clr_a = 1'b1; tick(); clr_a = 1'b0;
      chk("clr_final_unf", unf_a, 0);

      // DEPTH=2, AF=2, AE=0 boundaries
      chk("b_rst_ae", ae_b, 1);
      chk("b_rst_af", af_b, 0);
      wr_b = 1'b1; wd_b = 1'b1; tick();
      chk("b_c1_ae", ae_b, 0);
      chk("b_c1_af", af_b, 0);
      chk("b_c1_rdata", rdat_b, 1);
      wd_b = 1'b0; tick(); wr_b = 1'b0;
      chk("b_c2_full", full_b, 1);
      chk("b_c2_af", af_b, 1);
      chk("b_c2_count", cnt_b, 2);
      rd_b = 1'b1; tick();
      chk("b_pop1_rdata", rdat_b, 0);
      chk("b_pop1_af", af_b, 0);
      chk("b_pop1_empty", empty_b, 0);
      tick(); rd_b = 1'b0;
      chk("b_pop2_empty", empty_b, 1);
      chk("b_pop2_ae", ae_b, 1);
      chk("b_unf", unf_b, 0);

      // DEPTH=16, 16-bit data, AF=16, AE=0 boundaries
      chk("c_rst_ae", ae_c, 1);
      for (int i = 0; i < 16; i++) begin
         wr_c = 1'b1; wd_c = 16'h1000 + 16'(i * 16'h0111);
         tick();
         wr_c = 1'b0;
         chk("c_fill_af", af_c, (i == 15));
         chk("c_fill_ae", ae_c, 0);
      end
      chk("c_full", full_c, 1);
      chk("c_count", cnt_c, 16);
      chk("c_ovf", ovf_c, 0);
      for (int i = 0; i < 16; i++) begin
         chk("c_drain_data", rdat_c, 16'h1000 + 16'(i * 16'h0111));
         rd_c = 1'b1; tick(); rd_c = 1'b0;
      end
      chk("c_empty", empty_c, 1);
      chk("c_end_ae", ae_c, 1);
      chk("c_unf", unf_c, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
